uart_rx_display: RTL and testbench

- Serial receiver for the link the board's LED display shows.
- Deserialises 8N1 UART frames (8E1 with the optional feature) from the `rx` line using 16x oversampling.
- Pairs consecutive bytes into one 16-bit word and holds it on `signal_to_display` until the next complete pair arrives.
- Feeds the four-digit LED driver directly. Flags framing/parity errors for the status LEDs.

---
 rtl/uart_rx_display.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_display.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_display.sv
// rtl/uart_rx_display.sv - 16x-oversampled UART receiver that pairs bytes into a 16-bit display word
// Optional even parity (8E1 frame, live perror) when UART_RX_PARITY_EN is defined.
module uart_rx_display #(
  parameter int CLK_DIV  = 27,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] signal_to_display,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        byte_valid,
  output logic        ferror,
  output logic        perror
);

  localparam logic [9:0] DIV_M1 = 10'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [9:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]  os_cnt_q, os_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        ptr_q, ptr_d;
  logic [15:0] disp_q, disp_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        rx_valid_q, rx_valid_d;
  logic        ferror_q, ferror_d;
`ifdef UART_RX_PARITY_EN
  logic        perror_q, perror_d;
  logic        par_err_q, par_err_d;
`endif
  logic        tick;
  logic        good_stop;

  assign tick = (tick_cnt_q == 10'd0);

`ifdef UART_RX_PARITY_EN
  assign good_stop = ~par_err_q;
`else
  assign good_stop = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? DIV_M1 : 10'(tick_cnt_q - 10'd1);
    os_cnt_d     = os_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    ptr_d        = ptr_q;
    disp_d       = disp_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    rx_valid_d   = 1'b0;
    ferror_d     = ferror_q;
`ifdef UART_RX_PARITY_EN
    perror_d     = perror_q;
    par_err_d    = par_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          // Restart the tick phase at the falling edge so samples land mid-bit.
          state_d    = S_START;
          os_cnt_d   = 4'd0;
          tick_cnt_d = 10'd0;
        end
      end
      S_START: begin
        if (tick) begin
          if (os_cnt_q == 4'd7) begin
            os_cnt_d  = 4'd0;
            bit_idx_d = 3'd0;
            state_d   = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            shift_d   = {rx_s_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            par_err_d = rx_s_q ^ (^shift_q);
            state_d   = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            if (!rx_s_q) begin
              ferror_d = 1'b1;
              ptr_d    = 1'b0;
              state_d  = S_BREAK;
            end else if (!good_stop) begin
`ifdef UART_RX_PARITY_EN
              perror_d = 1'b1;
`endif
              ptr_d    = 1'b0;
              state_d  = S_IDLE;
            end else begin
              state_d      = S_IDLE;
              rx_byte_d    = shift_q;
              byte_valid_d = 1'b1;
              ferror_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
              perror_d     = 1'b0;
`endif
              if (!ptr_q) begin
                hold_d = shift_q;
                ptr_d  = 1'b1;
              end else begin
                disp_d     = HI_FIRST ? {hold_q, shift_q} : {shift_q, hold_q};
                rx_valid_d = 1'b1;
                ptr_d      = 1'b0;
              end
            end
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_cnt_q   <= 10'd0;
      os_cnt_q     <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      hold_q       <= 8'h00;
      ptr_q        <= 1'b0;
      disp_q       <= 16'h0000;
      rx_byte_q    <= 8'h00;
      byte_valid_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      ferror_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perror_q     <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      tick_cnt_q   <= tick_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      ptr_q        <= ptr_d;
      disp_q       <= disp_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      rx_valid_q   <= rx_valid_d;
      ferror_q     <= ferror_d;
`ifdef UART_RX_PARITY_EN
      perror_q     <= perror_d;
      par_err_q    <= par_err_d;
`endif
    end
  end

  assign signal_to_display = disp_q;
  assign rx_valid          = rx_valid_q;
  assign rx_byte           = rx_byte_q;
  assign byte_valid        = byte_valid_q;
  assign ferror            = ferror_q;
`ifdef UART_RX_PARITY_EN
  assign perror            = perror_q;
`else
  assign perror            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_display.sv
// tb/tb_uart_rx_display.sv - scoreboard bench for uart_rx_display, both HI_FIRST settings on one line
module tb_uart_rx_display;
  localparam int CLK_DIV = 4;
  localparam int BIT     = 16 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] disp_hi, disp_lo;
  logic        rv_hi, rv_lo, bv_hi, bv_lo, fe_hi, fe_lo, pe_hi, pe_lo;
  logic [7:0]  rb_hi, rb_lo;

  uart_rx_display #(.CLK_DIV(CLK_DIV), .HI_FIRST(1'b1)) dut_hi (
    .clk(clk), .reset(reset), .rx(rx), .signal_to_display(disp_hi), .rx_valid(rv_hi),
    .rx_byte(rb_hi), .byte_valid(bv_hi), .ferror(fe_hi), .perror(pe_hi));

  uart_rx_display #(.CLK_DIV(CLK_DIV), .HI_FIRST(1'b0)) dut_lo (
    .clk(clk), .reset(reset), .rx(rx), .signal_to_display(disp_lo), .rx_valid(rv_lo),
    .rx_byte(rb_lo), .byte_valid(bv_lo), .ferror(fe_lo), .perror(pe_lo));

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_b_hi[$], exp_b_lo[$];
  logic [15:0] exp_w_hi[$], exp_w_lo[$];
  bit          m_ptr = 1'b0;
  logic [7:0]  m_hold = 8'h00;
  int          fe_rise = 0;
  logic        fe_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
  bit          par_flip_g = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got output %0h with nothing expected", name, act);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_b_hi.push_back(b);
    exp_b_lo.push_back(b);
    if (!m_ptr) begin
      m_hold = b;
      m_ptr  = 1'b1;
    end else begin
      exp_w_hi.push_back({m_hold, b});
      exp_w_lo.push_back({b, m_hold});
      m_ptr = 1'b0;
    end
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit((^d) ^ par_flip_g);
`endif
    hold_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    expect_byte(d);
    send_frame(d, 1'b1);
  endtask

  // Monitor: every output pulse is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (bv_hi) begin
        if (exp_b_hi.size() == 0) unexpected("hi_byte", {24'b0, rb_hi});
        else begin
          check("hi_rx_byte", {24'b0, rb_hi}, {24'b0, exp_b_hi.pop_front()});
          check("hi_flags_on_byte", {30'b0, fe_hi, pe_hi}, 32'd0);
        end
      end
      if (bv_lo) begin
        if (exp_b_lo.size() == 0) unexpected("lo_byte", {24'b0, rb_lo});
        else begin
          check("lo_rx_byte", {24'b0, rb_lo}, {24'b0, exp_b_lo.pop_front()});
          check("lo_flags_on_byte", {30'b0, fe_lo, pe_lo}, 32'd0);
        end
      end
      if (rv_hi) begin
        if (exp_w_hi.size() == 0) unexpected("hi_word", {16'b0, disp_hi});
        else begin
          check("hi_word", {16'b0, disp_hi}, {16'b0, exp_w_hi.pop_front()});
          check("hi_word_with_byte", {31'b0, bv_hi}, 32'd1);
        end
      end
      if (rv_lo) begin
        if (exp_w_lo.size() == 0) unexpected("lo_word", {16'b0, disp_lo});
        else check("lo_word", {16'b0, disp_lo}, {16'b0, exp_w_lo.pop_front()});
      end
      if (fe_hi && !fe_prev) fe_rise++;
    end
    fe_prev = fe_hi;
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_disp_hi"}, {16'b0, disp_hi}, 32'h0);
    check({tag, "_disp_lo"}, {16'b0, disp_lo}, 32'h0);
    check({tag, "_rx_byte"}, {24'b0, rb_hi}, 32'h0);
    check({tag, "_pulses"}, {28'b0, bv_hi, rv_hi, bv_lo, rv_lo}, 32'h0);
    check({tag, "_flags"}, {28'b0, fe_hi, pe_hi, fe_lo, pe_lo}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    send_good(8'hA5);
    send_good(8'h3C);
    repeat (20) @(negedge clk);
    check("pair_disp_hi", {16'b0, disp_hi}, 32'hA53C);
    check("pair_disp_lo", {16'b0, disp_lo}, 32'h3CA5);
    check("pair_last_byte", {24'b0, rb_hi}, 32'h3C);

    rx = 1'b0;
    repeat (3 * CLK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_flags", {28'b0, fe_hi, pe_hi, fe_lo, pe_lo}, 32'h0);
    check("glitch_disp", {16'b0, disp_hi}, 32'hA53C);

    send_frame(8'h55, 1'b0);
    m_ptr = 1'b0;
    repeat (BIT) @(negedge clk);
    check("framing_ferror", {30'b0, fe_hi, fe_lo}, 32'h3);
    check("framing_rx_byte", {24'b0, rb_hi}, 32'h3C);
    send_good(8'h12);
    send_good(8'h34);
    repeat (20) @(negedge clk);
    check("after_ferror_disp_hi", {16'b0, disp_hi}, 32'h1234);
    check("after_ferror_disp_lo", {16'b0, disp_lo}, 32'h3412);
    check("ferror_cleared", {30'b0, fe_hi, fe_lo}, 32'h0);

    send_good(8'hBE);
    send_good(8'hEF);
    repeat (20) @(negedge clk);
    check("beef_disp", {16'b0, disp_hi}, 32'hBEEF);
    hold_bit(1'b0);
    for (int i = 0; i < 5; i++) hold_bit(1'b1);
    rx = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    rx = 1'b1;
    reset = 1'b0;
    m_ptr = 1'b0;
    check_idle_outputs("midframe_reset");
    repeat (2 * BIT) @(negedge clk);
    check("midframe_reset_disp_later", {16'b0, disp_hi}, 32'h0);
    send_good(8'h01);
    send_good(8'h02);
    repeat (20) @(negedge clk);
    check("post_reset_disp_hi", {16'b0, disp_hi}, 32'h0102);
    check("post_reset_disp_lo", {16'b0, disp_lo}, 32'h0201);

    fe_rise = 0;
    rx = 1'b0;
    repeat (30 * BIT) @(negedge clk);
    check("held_low_ferror", {31'b0, fe_hi}, 32'h1);
    check("held_low_one_error", fe_rise, 32'd1);
    rx = 1'b1;
    m_ptr = 1'b0;
    repeat (BIT) @(negedge clk);
    check("held_low_sticky", {31'b0, fe_hi}, 32'h1);

`ifdef UART_RX_PARITY_EN
    par_flip_g = 1'b1;
    send_frame(8'h07, 1'b1);
    m_ptr = 1'b0;
    repeat (BIT) @(negedge clk);
    check("parity_perror", {30'b0, pe_hi, pe_lo}, 32'h3);
    par_flip_g = 1'b0;
    send_good(8'h07);
    repeat (20) @(negedge clk);
    check("parity_cleared", {30'b0, pe_hi, pe_lo}, 32'h0);
    check("parity_rx_byte", {24'b0, rb_hi}, 32'h07);
`endif

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 1'b0;
    send_good(8'hCD);
    send_good(8'hAB);
    send_good(8'h11);
    send_good(8'h22);
    repeat (40) @(negedge clk);
    check("stream_disp_hi", {16'b0, disp_hi}, 32'h1122);
    check("stream_disp_lo", {16'b0, disp_lo}, 32'h2211);
    check("bytes_outstanding", exp_b_hi.size() + exp_b_lo.size(), 32'd0);
    check("words_outstanding", exp_w_hi.size() + exp_w_lo.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
